mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Sequential arbiter sharing the single-ported RAM between the instruction fetch port (icache side) and the data port (dcache side) of the pipelined CPU. Data requests win by default so the MEM stage clears and the hazard unit can release the pipeline. A streak counter bounds instruction starvation. The block sits between the caches/datapath and the RAM model and drives the `iwait`/`dwait` handshake that produces `ihit`/`dhit` upstream.

## Interface
- `MAX_DSTREAK`, default 4: consecutive data grants allowed while an instruction request is pending before the instruction port is forced; range 1..15.
- `CLK`  in  1  system clock, rising edge.
- `nRST`  in  1  asynchronous reset, active low.
- `iREN`  in  1  instruction read request.
- `iaddr`  in  32  instruction word address.
- `dREN`  in  1  data read request.
- `dWEN`  in  1  data write request.
- `daddr`  in  32  data address.
- `dstore`  in  32  data to write.
- `ramstate`  in  2  RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3.
- `ramload`  in  32  RAM read data.
- `iwait`  out  1  low for exactly the cycle instruction data is valid.
- `dwait`  out  1  low for exactly the cycle a data access completes.
- `iload`  out  32  instruction read data.
- `dload`  out  32  data read data.
- `ramREN`  out  1  RAM read enable.
- `ramWEN`  out  1  RAM write enable.
- `ramaddr`  out  32  RAM address.
- `ramstore`  out  32  RAM write data.
- `err_count`  out  8  saturating count of ERROR responses.

## Operation
- States: IDLE, DGNT, IGNT. Registered; all RAM controls decoded from state.
- IDLE: no RAM enables. Arbitration on registered next-state:
  - data request (`dREN|dWEN`) and not (`iREN` and streak == MAX_DSTREAK) -> DGNT;
  - else `iREN` -> IGNT;
  - else stay IDLE.
- DGNT: `ramaddr=daddr`, `ramstore=dstore`, `ramWEN=dWEN`, `ramREN=dREN&~dWEN`. `dREN` and `dWEN` both high is treated as a write.
- IGNT: `ramaddr=iaddr`, `ramREN=1`, `ramWEN=0`, `ramstore=0`.
- Completion: in a grant state with `ramstate==ACCESS`:
  - the granted port's wait is driven 0 combinationally that cycle;
  - `ramload` is routed to that port's load;
  - next state is IDLE.
- Waits are 1 in every other cycle.
- Load outputs: the load of the non-granted port and both loads outside completion are 0.
- Streak counter (4 bits):
  - on DGNT completion with `iREN` high, increment, saturating at MAX_DSTREAK;
  - on DGNT completion with `iREN` low, clear;
  - on IGNT completion, clear.
- Withdrawal: granted request deasserts (flush) in a grant state while `ramstate!=ACCESS` -> IDLE next cycle, no wait pulse, streak unchanged.
- ERROR: `ramstate==ERROR` in a grant state -> stay in state, retry (enables stay asserted); `err_count` increments, saturating at 255; no wait pulse.
- BUSY/FREE in a grant state: hold state and outputs.

## Timing
- Reset (async, `nRST` low):
  - state IDLE, streak 0, `err_count` 0;
  - `iwait=1`, `dwait=1`, `iload=0`, `dload=0`;
  - `ramREN=0`, `ramWEN=0`, `ramaddr=0`, `ramstore=0`.
- Reset mid-grant aborts the access immediately (enables drop asynchronously); no wait pulse is produced.
- Latency: request sampled in IDLE at edge N -> enables asserted from N+1. A zero-latency RAM (ACCESS in the first grant cycle) completes in that cycle, so the minimum is 2 cycles from request to wait low.
- Back-to-back accesses are separated by one IDLE bubble cycle with enables low.
- Simultaneous `iREN` and data request in IDLE: data wins unless streak == MAX_DSTREAK.
- Address and store are combinational pass-through from the granted port; requesters hold them stable until their wait goes low.

## Test plan
- Reset, no requests: `ramREN=ramWEN=0`, `iwait=dwait=1`, `err_count=0`; stays IDLE for 10 cycles.
- `iREN=1`, `iaddr=0x40`; RAM returns ACCESS after 2 BUSY cycles with `ramload=0x3C010001` -> `ramaddr=0x40`, `ramREN=1` for 3 cycles, `iwait=0` and `iload=0x3C010001` in the 3rd cycle only.
- `iREN` and `dWEN` raised together, `daddr=0x100`, `dstore=0xDEADBEEF` -> DGNT first with `ramWEN=1`; after `dwait` pulse, one IDLE cycle, then IGNT.
- MAX_DSTREAK=4, `iREN` and `dREN` held continuously, RAM always ACCESS -> grant order D,D,D,D,I,D,D,D,D,I.
- Grant DGNT, RAM BUSY; drop `dREN` -> IDLE next cycle, `dwait` never 0; RAM ERROR for 3 cycles then ACCESS -> `err_count=3`, single wait pulse.
- Assert `nRST` low during a BUSY IGNT -> `ramREN=0` immediately, `iwait=1`; after release, pending `iREN` is regranted 1 cycle later.

Source files
------------

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - arbitrates a single-ported RAM between instruction fetch and data ports
module mem_arbiter #(
    parameter int unsigned MAX_DSTREAK = 4
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    input  logic [1:0]  ramstate,
    input  logic [31:0] ramload,
    output logic        iwait,
    output logic        dwait,
    output logic [31:0] iload,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    output logic [7:0]  err_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DGNT = 2'd1,
        IGNT = 2'd2
    } state_t;

    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;
    localparam logic [3:0] STREAK_MAX = 4'(MAX_DSTREAK);

    state_t     state_q;
    logic [3:0] streak_q;
    logic [7:0] err_q;

    logic dreq;
    logic done;
    logic ram_err;

    assign dreq    = dREN | dWEN;
    assign done    = (ramstate == RAM_ACCESS);
    assign ram_err = (ramstate == RAM_ERROR);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= IDLE;
            streak_q <= 4'd0;
            err_q    <= 8'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    // Data wins unless the instruction side has waited out a full streak.
                    if (dreq && !(iREN && streak_q == STREAK_MAX))
                        state_q <= DGNT;
                    else if (iREN)
                        state_q <= IGNT;
                end
                DGNT: begin
                    if (done) begin
                        state_q <= IDLE;
                        if (!iREN)
                            streak_q <= 4'd0;
                        else if (streak_q < STREAK_MAX)
                            streak_q <= streak_q + 4'd1;
                    end else if (!dreq) begin
                        state_q <= IDLE;
                    end
                end
                IGNT: begin
                    if (done) begin
                        state_q  <= IDLE;
                        streak_q <= 4'd0;
                    end else if (!iREN) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
            // ERROR keeps the grant and retries; only the counter moves.
            if (state_q != IDLE && ram_err && err_q != 8'hFF)
                err_q <= err_q + 8'd1;
        end
    end

    always_comb begin
        iwait    = 1'b1;
        dwait    = 1'b1;
        iload    = 32'd0;
        dload    = 32'd0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = 32'd0;
        ramstore = 32'd0;
        case (state_q)
            DGNT: begin
                ramaddr  = daddr;
                ramstore = dstore;
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                if (done) begin
                    dwait = 1'b0;
                    dload = ramload;
                end
            end
            IGNT: begin
                ramaddr = iaddr;
                ramREN  = 1'b1;
                if (done) begin
                    iwait = 1'b0;
                    iload = ramload;
                end
            end
            default: ;
        endcase
    end

    assign err_count = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed scoreboard bench for mem_arbiter
module tb_mem_arbiter;

    localparam logic [31:0] K = 32'hA5A5_0000;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore;
    logic [1:0]  ramstate;
    logic [31:0] ramload;
    logic        iwait, dwait;
    logic [31:0] iload, dload;
    logic        ramREN, ramWEN;
    logic [31:0] ramaddr, ramstore;
    logic [7:0]  err_count;

    logic        use_fixed;
    logic [31:0] fixed_load;

    typedef struct packed {
        logic        port;
        logic [31:0] load;
    } ev_t;

    ev_t sb[$];
    int  n_cmp = 0;
    int  n_bad = 0;

    always #5 CLK = ~CLK;

    assign ramload = use_fixed ? fixed_load : (ramaddr ^ K);

    mem_arbiter #(.MAX_DSTREAK(4)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .ramstate(ramstate), .ramload(ramload),
        .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .err_count(err_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic smp();
        @(negedge CLK);
    endtask

    task automatic push(input logic port, input logic [31:0] ld);
        ev_t e;
        e.port = port;
        e.load = ld;
        sb.push_back(e);
    endtask

    // Every wait pulse must match the oldest outstanding expectation.
    ev_t got, exp_ev;
    always @(negedge CLK) begin
        if (nRST === 1'b1 && (iwait === 1'b0 || dwait === 1'b0)) begin
            got.port = (dwait === 1'b0);
            got.load = got.port ? dload : iload;
            check("single_wait_pulse", {30'd0, iwait, dwait}, got.port ? 32'd2 : 32'd1);
            check("idle_port_load", got.port ? iload : dload, 32'd0);
            check("pulse_expected", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                exp_ev = sb.pop_front();
                check("pulse_port", {31'd0, got.port}, {31'd0, exp_ev.port});
                check("pulse_load", got.load, exp_ev.load);
            end
        end
    end

    initial begin
        nRST = 1'b0; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
        iaddr = '0; daddr = '0; dstore = '0; ramstate = 2'd0;
        use_fixed = 1'b0; fixed_load = '0;

        repeat (2) smp();
        check("rst_iwait", {31'd0, iwait}, 32'd1);
        check("rst_dwait", {31'd0, dwait}, 32'd1);
        check("rst_iload", iload, 32'd0);
        check("rst_dload", dload, 32'd0);
        check("rst_ramREN", {31'd0, ramREN}, 32'd0);
        check("rst_ramWEN", {31'd0, ramWEN}, 32'd0);
        check("rst_ramaddr", ramaddr, 32'd0);
        check("rst_ramstore", ramstore, 32'd0);
        check("rst_err", {24'd0, err_count}, 32'd0);
        step();
        nRST = 1'b1;
        repeat (10) begin
            smp();
            check("idle_en", {30'd0, ramREN, ramWEN}, 32'd0);
            check("idle_waits", {30'd0, iwait, dwait}, 32'd3);
            check("idle_err", {24'd0, err_count}, 32'd0);
        end

        // Instruction fetch, two BUSY cycles then ACCESS
        step();
        iREN = 1'b1; iaddr = 32'h40; ramstate = 2'd1;
        use_fixed = 1'b1; fixed_load = 32'h3C01_0001;
        push(1'b0, 32'h3C01_0001);
        for (int c = 0; c < 3; c++) begin
            step();
            if (c == 2) ramstate = 2'd2;
            smp();
            check("if_ramREN", {31'd0, ramREN}, 32'd1);
            check("if_ramaddr", ramaddr, 32'h40);
            check("if_iwait", {31'd0, iwait}, (c == 2) ? 32'd0 : 32'd1);
            check("if_iload", iload, (c == 2) ? 32'h3C01_0001 : 32'd0);
        end
        step();
        iREN = 1'b0; ramstate = 2'd0; use_fixed = 1'b0;
        smp();
        check("if_after_en", {31'd0, ramREN}, 32'd0);

        // Simultaneous write and fetch: data first, one bubble, then fetch
        step();
        iREN = 1'b1; iaddr = 32'h200;
        dWEN = 1'b1; daddr = 32'h100; dstore = 32'hDEAD_BEEF; ramstate = 2'd2;
        push(1'b1, 32'h100 ^ K);
        push(1'b0, 32'h200 ^ K);
        step(); smp();
        check("wr_ramWEN", {31'd0, ramWEN}, 32'd1);
        check("wr_ramREN", {31'd0, ramREN}, 32'd0);
        check("wr_ramaddr", ramaddr, 32'h100);
        check("wr_ramstore", ramstore, 32'hDEAD_BEEF);
        check("wr_dwait", {31'd0, dwait}, 32'd0);
        step();
        dWEN = 1'b0;
        smp();
        check("wr_bubble_en", {30'd0, ramREN, ramWEN}, 32'd0);
        step(); smp();
        check("wr_ignt_ren", {31'd0, ramREN}, 32'd1);
        check("wr_ignt_addr", ramaddr, 32'h200);
        check("wr_ignt_store", ramstore, 32'd0);
        check("wr_ignt_iwait", {31'd0, iwait}, 32'd0);
        step();
        iREN = 1'b0;
        smp();
        check("wr_done_en", {31'd0, ramREN}, 32'd0);

        // Starvation bound: D,D,D,D,I,D,D,D,D,I
        step();
        iREN = 1'b1; dREN = 1'b1; iaddr = 32'h300; daddr = 32'h400;
        for (int g = 0; g < 10; g++) begin
            if (g == 4 || g == 9) push(1'b0, 32'h300 ^ K);
            else push(1'b1, 32'h400 ^ K);
        end
        repeat (19) begin
            step(); smp();
        end
        step();
        iREN = 1'b0; dREN = 1'b0;
        smp();
        check("streak_sb_empty", 32'(sb.size()), 32'd0);
        check("streak_idle_en", {31'd0, ramREN}, 32'd0);

        // Withdrawal during BUSY
        step();
        dREN = 1'b1; daddr = 32'h500; ramstate = 2'd1;
        step(); smp();
        check("wd_ramREN", {31'd0, ramREN}, 32'd1);
        check("wd_ramaddr", ramaddr, 32'h500);
        step();
        dREN = 1'b0;
        smp();
        check("wd_dwait", {31'd0, dwait}, 32'd1);
        step(); smp();
        check("wd_idle_en", {30'd0, ramREN, ramWEN}, 32'd0);

        // ERROR retries then ACCESS
        step();
        dREN = 1'b1; daddr = 32'h600; ramstate = 2'd3;
        push(1'b1, 32'h600 ^ K);
        smp();
        check("err_latency", {31'd0, ramREN}, 32'd0);
        for (int c = 0; c < 3; c++) begin
            step(); smp();
            check("err_ramREN", {31'd0, ramREN}, 32'd1);
            check("err_dwait", {31'd0, dwait}, 32'd1);
            check("err_count_run", {24'd0, err_count}, 32'(c));
        end
        step();
        ramstate = 2'd2;
        smp();
        check("err_count_3", {24'd0, err_count}, 32'd3);
        check("err_done_dwait", {31'd0, dwait}, 32'd0);
        step();
        dREN = 1'b0; ramstate = 2'd0;
        smp();
        check("err_after_en", {31'd0, ramREN}, 32'd0);
        check("err_hold", {24'd0, err_count}, 32'd3);

        // Reset mid-grant, then regrant after release
        step();
        iREN = 1'b1; iaddr = 32'h700; ramstate = 2'd1;
        step(); smp();
        check("mr_ramREN", {31'd0, ramREN}, 32'd1);
        #2;
        nRST = 1'b0;
        #1;
        check("mr_async_ren", {31'd0, ramREN}, 32'd0);
        check("mr_async_iwait", {31'd0, iwait}, 32'd1);
        check("mr_async_addr", ramaddr, 32'd0);
        check("mr_async_err", {24'd0, err_count}, 32'd0);
        step();
        ramstate = 2'd2;
        push(1'b0, 32'h700 ^ K);
        step();
        nRST = 1'b1;
        smp();
        check("mr_rel_idle", {31'd0, ramREN}, 32'd0);
        step(); smp();
        check("mr_regrant_ren", {31'd0, ramREN}, 32'd1);
        check("mr_regrant_addr", ramaddr, 32'h700);
        check("mr_regrant_iwait", {31'd0, iwait}, 32'd0);
        step();
        iREN = 1'b0; ramstate = 2'd0;
        smp();
        check("mr_final_en", {31'd0, ramREN}, 32'd0);
        check("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
